// File: rtl/fifo_ctrl_pkg.sv
// ============================================================================
// Module : fifo_ctrl_pkg
// Brief  : Shared default sizing and operation encoding for the FIFO controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fifo_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 7;
    localparam int DEF_AE_LEVEL   = 4;

    // almost_full threshold sits four entries below capacity by default
    function automatic int def_af_level(input int addr_width);
        return (2 ** addr_width) - 4;
    endfunction

    // Encoded as {rd_ok, wr_ok} so the accepted-request pair maps directly
    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

`default_nettype wire

// File: rtl/fifo_ctrl.sv
// ============================================================================
// Module : fifo_ctrl
// Brief  : Pointer, count and flag controller driving a reg_file as a FWFT FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_LEVEL   = def_af_level(ADDR_WIDTH),
    parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] address_w,
    output logic [ADDR_WIDTH-1:0] address_r,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   C_CNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   C_DEPTH   = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   C_AF      = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   C_AE      = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;

    logic                  wr_ok;
    logic                  rd_ok;
    fifo_op_e              op;

    always_comb begin
        // A push into a full FIFO is only legal when a pop frees the slot this cycle
        wr_ok = wr & (~full_q | rd);
        // No bypass: a pop on an empty FIFO is dropped even with a concurrent push
        rd_ok = rd & ~empty_q;
        op    = fifo_op_e'({rd_ok, wr_ok});
    end

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        case (op)
            OP_PUSH: begin
                w_ptr_d = w_ptr_q + C_PTR_ONE;
                count_d = count_q + C_CNT_ONE;
            end
            OP_POP: begin
                r_ptr_d = r_ptr_q + C_PTR_ONE;
                count_d = count_q - C_CNT_ONE;
            end
            OP_BOTH: begin
                w_ptr_d = w_ptr_q + C_PTR_ONE;
                r_ptr_d = r_ptr_q + C_PTR_ONE;
            end
            default: begin
                w_ptr_d = w_ptr_q;
                r_ptr_d = r_ptr_q;
                count_d = count_q;
            end
        endcase

        full_d  = (count_d == C_DEPTH);
        empty_d = (count_d == '0);
        af_d    = (count_d >= C_AF);
        ae_d    = (count_d <= C_AE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
        end
    end

    // Write strobe is combinational, so it must be masked while reset is held
    assign we           = wr_ok & ~reset;
    assign address_w    = w_ptr_q;
    assign address_r    = r_ptr_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
// ============================================================================
// Module : tb_fifo_ctrl
// Brief  : Self-checking bench for fifo_ctrl with a depth-4 storage array model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       wr;
    logic       rd;
    logic       we;
    logic [1:0] address_w;
    logic [1:0] address_r;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] count;

    logic [7:0] data_w;
    logic [7:0] mem [DEPTH];
    logic [7:0] data_r;

    int total;
    int bad;

    // Reference model: contents as a queue plus logical pointers
    logic [7:0] q [$];
    int         wp;
    int         rp;

    logic       s_we;
    logic [7:0] s_dr;

    fifo_ctrl #(
        .ADDR_WIDTH (AW),
        .AF_LEVEL   (3),
        .AE_LEVEL   (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .rd           (rd),
        .we           (we),
        .address_w    (address_w),
        .address_r    (address_r),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (we) mem[address_w] <= data_w;
    end

    assign data_r = mem[address_r];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wp = 0;
        rp = 0;
    endtask

    task automatic chk_state();
        int n;
        n = q.size();
        chk("count",        32'(count),        32'(n));
        chk("full",         32'(full),         32'(n == DEPTH));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("almost_full",  32'(almost_full),  32'(n >= 3));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
        chk("address_w",    32'(address_w),    32'(wp));
        chk("address_r",    32'(address_r),    32'(rp));
    endtask

    // Called just after a rising edge; leaves time just after the next one
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        logic exp_we;
        logic rd_acc;
        exp_we = w && ((q.size() < DEPTH) || r);
        rd_acc = r && (q.size() > 0);
        wr     = w;
        rd     = r;
        data_w = d;
        #3;
        s_we = we;
        s_dr = data_r;
        chk("we", 32'(we), 32'(exp_we));
        if (rd_acc) chk("data_r", 32'(data_r), 32'(q[0]));
        @(posedge clk);
        #1;
        if (rd_acc) begin
            void'(q.pop_front());
            rp = (rp + 1) % DEPTH;
        end
        if (exp_we) begin
            q.push_back(d);
            wp = (wp + 1) % DEPTH;
        end
        chk_state();
    endtask

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic       chk_dr;
        logic [7:0] dr;
        logic       we;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic [1:0] aw;
        logic [1:0] ar;
    } vec_t;

    vec_t tbl [12];

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        wr     = 1'b0;
        rd     = 1'b0;
        data_w = 8'h00;
        model_reset();

        //           wr  rd  din    cdr  dr     we  cnt f  e  af ae aw ar
        tbl[0]  = '{1'b1, 1'b0, 8'hA1, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0};
        tbl[1]  = '{1'b1, 1'b0, 8'hB2, 1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0};
        tbl[2]  = '{1'b1, 1'b0, 8'hC3, 1'b0, 8'h00, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0};
        tbl[3]  = '{1'b1, 1'b0, 8'hD4, 1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
        tbl[4]  = '{1'b1, 1'b0, 8'h55, 1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
        tbl[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'hA1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1};
        tbl[6]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'hB2, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2};
        tbl[7]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'hC3, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3};
        tbl[8]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'hD4, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0};
        tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0};
        tbl[10] = '{1'b1, 1'b1, 8'hE5, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hE5, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we",    32'(we),    32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
        chk("idle_empty", 32'(empty),        32'd1);
        chk("idle_full",  32'(full),         32'd0);
        chk("idle_ae",    32'(almost_empty), 32'd1);
        chk("idle_aw",    32'(address_w),    32'd0);
        chk("idle_ar",    32'(address_r),    32'd0);

        // Directed table: fill, overflow, drain, underflow, push+pop on empty
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].din);
            chk("tbl_we", 32'(s_we), 32'(tbl[i].we));
            if (tbl[i].chk_dr) chk("tbl_data_r", 32'(s_dr), 32'(tbl[i].dr));
            chk("tbl_count", 32'(count),        32'(tbl[i].cnt));
            chk("tbl_full",  32'(full),         32'(tbl[i].full));
            chk("tbl_empty", 32'(empty),        32'(tbl[i].empty));
            chk("tbl_af",    32'(almost_full),  32'(tbl[i].af));
            chk("tbl_ae",    32'(almost_empty), 32'(tbl[i].ae));
            chk("tbl_aw",    32'(address_w),    32'(tbl[i].aw));
            chk("tbl_ar",    32'(address_r),    32'(tbl[i].ar));
        end

        // Fill to full, then simultaneous push/pop across a pointer wrap
        step(1'b1, 1'b0, 8'h16);
        step(1'b1, 1'b0, 8'h27);
        step(1'b1, 1'b0, 8'h38);
        chk("fill_full", 32'(full), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 8'h80 + 8'(i));
            chk("both_full",  32'(full),  32'd1);
            chk("both_count", 32'(count), 32'd4);
        end
        chk("wrap_aw", 32'(address_w), 32'd2);
        chk("wrap_ar", 32'(address_r), 32'd2);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00);
        chk("drain_empty", 32'(empty), 32'd1);

        // Random traffic against the queue model
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
                 8'($urandom));
        end

        // Asynchronous reset in the middle of a cycle
        step(1'b1, 1'b0, 8'hF1);
        step(1'b1, 1'b0, 8'hF2);
        wr     = 1'b1;
        data_w = 8'hF3;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(count),        32'd0);
        chk("arst_empty", 32'(empty),        32'd1);
        chk("arst_full",  32'(full),         32'd0);
        chk("arst_ae",    32'(almost_empty), 32'd1);
        chk("arst_af",    32'(almost_full),  32'd0);
        chk("arst_aw",    32'(address_w),    32'd0);
        chk("arst_ar",    32'(address_r),    32'd0);
        chk("arst_we",    32'(we),           32'd0);
        wr = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 8'h99);
        step(1'b0, 1'b1, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
